// File: rtl/sipo_frame_ctrl.sv
// Sequencing controller for a WIDTH-bit SIPO: gates the shift enable from a framed
// serial stream, captures each full frame and offers it on a valid/ready handshake.
module sipo_frame_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_valid,
   input  logic             frame_start,
   output logic             sipo_shift_en,
   input  logic [WIDTH-1:0] sipo_q,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } state_t;

   // A one-bit frame is complete as soon as its first bit has shifted in.
   localparam state_t           FIRST_STATE = (WIDTH == 1) ? LOAD : SHIFT;
   localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             capture;
   logic             drop;
   logic             restart;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt     = state;
      cnt_nxt       = bit_cnt;
      sipo_shift_en = 1'b0;
      capture       = 1'b0;
      drop          = 1'b0;
      restart       = 1'b0;
      unique case (state)
         IDLE: begin
            if (serial_valid && frame_start) begin
               sipo_shift_en = 1'b1;
               cnt_nxt       = ONE_CNT;
               state_nxt     = FIRST_STATE;
            end
         end
         SHIFT: begin
            if (serial_valid) begin
               sipo_shift_en = 1'b1;
               if (frame_start) begin
                  // Restart mid-frame: the next WIDTH shifts flush the stale bits.
                  restart   = 1'b1;
                  cnt_nxt   = ONE_CNT;
                  state_nxt = FIRST_STATE;
               end else begin
                  cnt_nxt = bit_cnt + ONE_CNT;
                  if (bit_cnt == LAST_CNT) begin
                     state_nxt = LOAD;
                  end
               end
            end
         end
         LOAD: begin
            if (!word_valid || word_ready) begin
               capture = 1'b1;
            end else begin
               drop = 1'b1;
            end
            // sipo_q is sampled before this edge's shift, so a new frame may start here.
            if (serial_valid && frame_start) begin
               sipo_shift_en = 1'b1;
               cnt_nxt       = ONE_CNT;
               state_nxt     = FIRST_STATE;
            end else begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (capture) begin
            word_out   <= sipo_q;
            word_valid <= 1'b1;
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end

         // Set events take priority over a coincident clear.
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end

         if (restart) begin
            frame_err <= 1'b1;
         end else if (clr_err) begin
            frame_err <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed frame scenarios plus random traffic, checked
// against a frame-level model that collects bits into a queue and delivers whole words.
module tb_sipo_frame_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk          = 1'b0;
   logic             reset        = 1'b1;
   logic             serial_valid = 1'b0;
   logic             frame_start  = 1'b0;
   logic             serial_bit   = 1'b0;
   logic             word_ready   = 1'b0;
   logic             clr_err      = 1'b0;
   logic [WIDTH-1:0] sipo_q       = '0;
   logic             sipo_shift_en;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;
   logic             frame_err;

   int n_vec = 0;
   int n_err = 0;
   int shift_cycles;
   int valid_cycles;
   logic [WIDTH-1:0] last_word;

   // Frame-level reference: bits of the frame being assembled, the held word, sticky flags.
   bit               m_frame[$];
   logic [WIDTH-1:0] m_word;
   bit               m_valid;
   bit               m_ovr;
   bit               m_ferr;

   sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .sipo_shift_en(sipo_shift_en),
      .sipo_q       (sipo_q),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .busy         (busy),
      .bit_cnt      (bit_cnt),
      .overrun      (overrun),
      .frame_err    (frame_err),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   // Controlled shift register: first bit of a frame ends up as the MSB.
   always @(posedge clk) begin
      if (sipo_shift_en) sipo_q <= {sipo_q[WIDTH-2:0], serial_bit};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] frame_value();
      int v = 0;
      foreach (m_frame[i]) v = v * 2 + int'(m_frame[i]);
      return WIDTH'(v);
   endfunction

   function automatic bit exp_shift(input bit sv, input bit fs);
      int n = m_frame.size();
      return sv && (fs || (n > 0 && n < WIDTH));
   endfunction

   task automatic model_reset();
      m_frame.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
   endtask

   task automatic model_edge(input bit sv, input bit fs, input bit b, input bit rdy, input bit clr);
      int n       = m_frame.size();
      bit ovr_set = 1'b0;
      bit ferr_set = 1'b0;
      if (n == WIDTH) begin
         if (!m_valid || rdy) begin
            m_word  = frame_value();
            m_valid = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (sv && fs) begin
         if (n > 0 && n < WIDTH) ferr_set = 1'b1;
         m_frame.delete();
         m_frame.push_back(b);
      end else if (n == WIDTH) begin
         m_frame.delete();
      end else if (sv && n > 0) begin
         m_frame.push_back(b);
      end
      m_ovr  = ovr_set  || (m_ovr  && !clr);
      m_ferr = ferr_set || (m_ferr && !clr);
   endtask

   task automatic check_outputs();
      check("word_valid", 32'(word_valid), 32'(m_valid));
      check("word_out",   32'(word_out),   32'(m_word));
      check("busy",       32'(busy),       32'(m_frame.size() != 0));
      check("bit_cnt",    32'(bit_cnt),    32'(m_frame.size()));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("frame_err",  32'(frame_err),  32'(m_ferr));
      if (word_valid) begin
         valid_cycles++;
         last_word = word_out;
      end
   endtask

   // One clock: drive at the falling edge, check the combinational enable, then the registers.
   task automatic cycle(input bit sv, input bit fs, input bit b, input bit rdy, input bit clr);
      serial_valid = sv;
      frame_start  = fs;
      serial_bit   = b;
      word_ready   = rdy;
      clr_err      = clr;
      #1;
      check("sipo_shift_en", 32'(sipo_shift_en), 32'(exp_shift(sv, fs)));
      if (sipo_shift_en) shift_cycles++;
      @(posedge clk);
      model_edge(sv, fs, b, rdy, clr);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic apply_reset(input int cycles);
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      word_ready   = 1'b0;
      clr_err      = 1'b0;
      reset        = 1'b1;
      #1;
      model_reset();
      check_outputs();
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input bit rdy);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         cycle(1'b1, i == WIDTH - 1, w[i], rdy, 1'b0);
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      apply_reset(2);

      // Single frame, consumer always ready.
      shift_cycles = 0;
      valid_cycles = 0;
      send_frame(4'b1011, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp1_shift_cycles", 32'(shift_cycles), 32'd4);
      check("tp1_valid_pulse",  32'(valid_cycles), 32'd1);
      check("tp1_word",         32'(last_word),    32'hB);
      check("tp1_overrun",      32'(overrun),      32'd0);

      // Same frame with a three-cycle gap after bit 2.
      shift_cycles = 0;
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         check("tp2_gap_bit_cnt", 32'(bit_cnt), 32'd2);
         check("tp2_gap_busy",    32'(busy),    32'd1);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp2_shift_cycles", 32'(shift_cycles), 32'd4);
      check("tp2_word",         32'(last_word),    32'hB);

      // Back-to-back frames with a stalled consumer: the second is dropped.
      send_frame(4'b1011, 1'b0);
      send_frame(4'b0110, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("tp3_word_kept",  32'(word_out),   32'hB);
      check("tp3_overrun",    32'(overrun),    32'd1);
      check("tp3_valid_held", 32'(word_valid), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("tp3_overrun_clr", 32'(overrun), 32'd0);

      // Consumer accepts exactly in the LOAD cycle: replacement without overrun.
      send_frame(4'b0110, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("tp4_word_replaced", 32'(word_out),   32'h6);
      check("tp4_valid",         32'(word_valid), 32'd1);
      check("tp4_no_overrun",    32'(overrun),    32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp4_drained", 32'(word_valid), 32'd0);

      // frame_start reasserted at bit 3: one word from the four bits after the restart.
      valid_cycles = 0;
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("tp5_frame_err_set", 32'(frame_err), 32'd1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp5_word_count", 32'(valid_cycles), 32'd1);
      check("tp5_word",       32'(last_word),    32'h5);
      check("tp5_frame_err",  32'(frame_err),    32'd1);

      // Reset in SHIFT with bit_cnt=2 and frame_err still set.
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp6_pre_bit_cnt", 32'(bit_cnt), 32'd2);
      apply_reset(1);
      check("tp6_rst_word_out",  32'(word_out),   32'd0);
      check("tp6_rst_valid",     32'(word_valid), 32'd0);
      check("tp6_rst_busy",      32'(busy),       32'd0);
      check("tp6_rst_bit_cnt",   32'(bit_cnt),    32'd0);
      check("tp6_rst_overrun",   32'(overrun),    32'd0);
      check("tp6_rst_frame_err", 32'(frame_err),  32'd0);
      valid_cycles = 0;
      send_frame(4'b0011, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("tp6_word_after_rst", 32'(last_word),    32'h3);
      check("tp6_word_count",     32'(valid_cycles), 32'd1);

      // Random traffic against the frame model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            apply_reset(1);
         end else begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, 1'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
